// File: rtl/fifo_sr_pkg.sv
// Shared definitions for the tagged multi-flux FIFO read side.
// Tag/payload width derivation and a tag-extract helper.
package fifo_sr_pkg;

    // Tag bits needed to name every flux.
    function automatic int tag_w(input int flux);
        return $clog2(flux);
    endfunction

    // Payload bits left once the tag is stripped off the word.
    function automatic int pay_w(input int width, input int flux);
        return width - $clog2(flux);
    endfunction

    // Tag sits in the top tw bits of a width-bit word.
    function automatic int tag_of(
        input logic [63:0] word,
        input int          width,
        input int          tw
    );
        logic [63:0] s;
        s = word >> (width - tw);
        return int'(s & ((64'd1 << tw) - 64'd1));
    endfunction

endpackage

// File: rtl/fifo_sr_drain_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr.
// Ports: req/ptr in; one-hot gnt, gnt_idx and gnt_vld out.
module rr_arbiter #(
    parameter int FLUX = 2,
    parameter int TW   = 1
) (
    input  logic [FLUX-1:0] req,
    input  logic [TW-1:0]   ptr,
    output logic [FLUX-1:0] gnt,
    output logic [TW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    int          c;
    logic [TW-1:0] ci;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        c       = 0;
        ci      = '0;
        for (int k = 0; k < FLUX; k++) begin
            c  = (32'(ptr) + k) % FLUX;
            ci = c[TW-1:0];
            if (!gnt_vld && req[ci]) begin
                gnt_vld = 1'b1;
                gnt_idx = ci;
                gnt[ci] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_sr_drain.sv
// Read-side drain engine: round-robin rd pulses, tag check, per-flux output.
// Ports: ck/rst, en, fifo_empty/fifo_dataout/fifo_rd, out_data/valid/ready, tag_err.
module fifo_sr_drain
    import fifo_sr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = tag_w(FLUX),
    parameter int PW        = pay_w(WIDTH, FLUX)
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 en,
    input  logic [FLUX-1:0]      fifo_empty,
    input  logic [WIDTH-1:0]     fifo_dataout,
    output logic [FLUX-1:0]      fifo_rd,
    output logic [FLUX*PW-1:0]   out_data,
    output logic [FLUX-1:0]      out_valid,
    input  logic [FLUX-1:0]      out_ready,
    output logic                 tag_err
);

    logic [FLUX-1:0]      elig;
    logic [FLUX-1:0]      pend;
    logic [FLUX-1:0]      tag_ok;
    logic [FLUX-1:0]      bad;
    logic [FLUX-1:0]      gnt;
    logic [TAG_WIDTH-1:0] gnt_idx;
    logic                 gnt_vld;
    logic [TAG_WIDTH-1:0] rr_ptr;
    int                   rx_tag;

    // Tags >= FLUX never equal a flux index, so they always mismatch.
    assign rx_tag = tag_of(64'(fifo_dataout), WIDTH, TAG_WIDTH);

    rr_arbiter #(
        .FLUX (FLUX),
        .TW   (TAG_WIDTH)
    ) u_arb (
        .req     (elig),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign fifo_rd = rst ? '0 : gnt;

    // Grant sets pend; a granted flux is never pending, so the
    // grant vector alone is the next pend state.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            pend   <= '0;
            rr_ptr <= '0;
        end else begin
            pend <= fifo_rd;
            if (gnt_vld) begin
                rr_ptr <= (32'(gnt_idx) == FLUX - 1) ? '0
                                                      : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            tag_err <= 1'b0;
        end else if (|bad) begin
            tag_err <= 1'b1;
        end
    end

    for (genvar i = 0; i < FLUX; i++) begin : g_flux
        logic          v_q;
        logic [PW-1:0] d_q;
        logic          hit;

        assign tag_ok[i] = (rx_tag == i);
        assign hit       = pend[i] & tag_ok[i];
        assign bad[i]    = pend[i] & ~tag_ok[i];
        assign elig[i]   = en & ~fifo_empty[i] & ~pend[i]
                         & (~v_q | out_ready[i]);

        // A capture wins over the handshake clear at the same edge.
        always_ff @(posedge ck or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (hit) begin
                v_q <= 1'b1;
                d_q <= fifo_dataout[PW-1:0];
            end else if (v_q && out_ready[i]) begin
                v_q <= 1'b0;
            end
        end

        assign out_valid[i]          = v_q;
        assign out_data[i*PW +: PW]  = d_q;
    end

endmodule

// File: tb/tb_fifo_sr_drain.sv
// Self-checking bench for fifo_sr_drain (WIDTH=8, FLUX=2).
// Table-driven per-cycle vectors plus reset sequences.
module tb_fifo_sr_drain;

    logic        ck = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  fifo_empty;
    logic [7:0]  fifo_dataout;
    logic [1:0]  fifo_rd;
    logic [13:0] out_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic        tag_err;

    logic [7:0]  w0, w1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 ck = ~ck;

    fifo_sr_drain #(
        .WIDTH (8),
        .FLUX  (2)
    ) dut (
        .ck           (ck),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_dataout (fifo_dataout),
        .fifo_rd      (fifo_rd),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .tag_err      (tag_err)
    );

    // Minimal FIFO read port: registers the word of the flux read.
    always_ff @(posedge ck or posedge rst) begin
        if (rst)             fifo_dataout <= 8'h00;
        else if (fifo_rd[0]) fifo_dataout <= w0;
        else if (fifo_rd[1]) fifo_dataout <= w1;
    end

    typedef struct packed {
        logic       en;
        logic [1:0] emp;
        logic [1:0] rdy;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [1:0] rd;
        logic [1:0] vld;
        logic [6:0] d0;
        logic [6:0] d1;
        logic       err;
    } vec_t;

    localparam int NV = 19;
    vec_t tv [NV];

    function automatic vec_t mk(
        input logic       e,
        input logic [1:0] emp,
        input logic [1:0] rdy,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [1:0] rd,
        input logic [1:0] vld,
        input logic [6:0] d0,
        input logic [6:0] d1,
        input logic       err
    );
        vec_t v;
        v.en = e; v.emp = emp; v.rdy = rdy; v.w0 = a; v.w1 = b;
        v.rd = rd; v.vld = vld; v.d0 = d0; v.d1 = d1; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] rd,
                           input logic [1:0] vld, input logic [6:0] d0,
                           input logic [6:0] d1, input logic err);
        chk({tag, ".rd"},  32'(fifo_rd),        32'(rd));
        chk({tag, ".vld"}, 32'(out_valid),      32'(vld));
        chk({tag, ".d0"},  32'(out_data[6:0]),  32'(d0));
        chk({tag, ".d1"},  32'(out_data[13:7]), 32'(d1));
        chk({tag, ".err"}, 32'(tag_err),        32'(err));
    endtask

    initial begin
        // single flux, round-robin, backpressure, tag error, en low
        tv[0]  = mk(1, 2'b10, 2'b11, 8'h35, 8'h00, 2'b01, 2'b00, 7'h00, 7'h00, 0);
        tv[1]  = mk(1, 2'b10, 2'b11, 8'h35, 8'h00, 2'b00, 2'b00, 7'h00, 7'h00, 0);
        tv[2]  = mk(1, 2'b10, 2'b11, 8'h11, 8'h00, 2'b01, 2'b01, 7'h35, 7'h00, 0);
        tv[3]  = mk(1, 2'b11, 2'b11, 8'h00, 8'h00, 2'b00, 2'b00, 7'h35, 7'h00, 0);
        tv[4]  = mk(1, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 2'b01, 7'h11, 7'h00, 0);
        tv[5]  = mk(1, 2'b00, 2'b11, 8'h01, 8'h82, 2'b10, 2'b01, 7'h11, 7'h00, 0);
        tv[6]  = mk(1, 2'b00, 2'b11, 8'h01, 8'h82, 2'b01, 2'b00, 7'h11, 7'h00, 0);
        tv[7]  = mk(1, 2'b00, 2'b11, 8'h01, 8'h82, 2'b10, 2'b10, 7'h11, 7'h02, 0);
        tv[8]  = mk(1, 2'b00, 2'b11, 8'h01, 8'h82, 2'b01, 2'b01, 7'h01, 7'h02, 0);
        tv[9]  = mk(1, 2'b00, 2'b10, 8'h01, 8'h83, 2'b10, 2'b10, 7'h01, 7'h02, 0);
        tv[10] = mk(1, 2'b00, 2'b10, 8'h01, 8'h84, 2'b00, 2'b01, 7'h01, 7'h02, 0);
        tv[11] = mk(1, 2'b00, 2'b10, 8'h01, 8'h84, 2'b10, 2'b11, 7'h01, 7'h03, 0);
        tv[12] = mk(1, 2'b00, 2'b10, 8'h01, 8'h84, 2'b00, 2'b01, 7'h01, 7'h03, 0);
        tv[13] = mk(1, 2'b00, 2'b11, 8'h80, 8'h85, 2'b01, 2'b11, 7'h01, 7'h04, 0);
        tv[14] = mk(1, 2'b11, 2'b11, 8'h00, 8'h00, 2'b00, 2'b00, 7'h01, 7'h04, 0);
        tv[15] = mk(1, 2'b10, 2'b11, 8'h06, 8'h00, 2'b01, 2'b00, 7'h01, 7'h04, 1);
        tv[16] = mk(0, 2'b00, 2'b11, 8'h07, 8'h87, 2'b00, 2'b00, 7'h01, 7'h04, 1);
        tv[17] = mk(0, 2'b00, 2'b11, 8'h07, 8'h87, 2'b00, 2'b01, 7'h06, 7'h04, 1);
        tv[18] = mk(1, 2'b11, 2'b11, 8'h00, 8'h00, 2'b00, 2'b00, 7'h06, 7'h04, 1);

        // reset with traffic available: rd forced low
        rst = 1'b1; en = 1'b1; fifo_empty = 2'b00; out_ready = 2'b00;
        w0 = 8'h00; w1 = 8'h00;
        @(negedge ck); #1;
        chk_all("rst_hold", 2'b00, 2'b00, 7'h00, 7'h00, 1'b0);
        @(negedge ck);
        rst = 1'b0; fifo_empty = 2'b11;
        #1;
        chk_all("rst_after", 2'b00, 2'b00, 7'h00, 7'h00, 1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge ck);
            en = tv[i].en; fifo_empty = tv[i].emp; out_ready = tv[i].rdy;
            w0 = tv[i].w0; w1 = tv[i].w1;
            #1;
            chk_all($sformatf("vec%0d", i), tv[i].rd, tv[i].vld,
                    tv[i].d0, tv[i].d1, tv[i].err);
        end

        // reset in the cycle after a grant drops the in-flight word
        @(negedge ck);
        en = 1'b1; fifo_empty = 2'b10; out_ready = 2'b11; w0 = 8'h07;
        #1;
        chk("mid.grant", 32'(fifo_rd), 32'h1);
        @(negedge ck);
        rst = 1'b1; fifo_empty = 2'b11;
        #1;
        chk_all("mid.rst", 2'b00, 2'b00, 7'h00, 7'h00, 1'b0);
        @(negedge ck);
        rst = 1'b0;
        #1;
        chk_all("mid.post", 2'b00, 2'b00, 7'h00, 7'h00, 1'b0);
        @(negedge ck); #1;
        chk("mid.post2.vld", 32'(out_valid), 32'h0);
        // pointer back at 0: flux0 wins with both requesting
        @(negedge ck);
        fifo_empty = 2'b00; w0 = 8'h09; w1 = 8'h8a;
        #1;
        chk("mid.rr_reset", 32'(fifo_rd), 32'h1);
        @(negedge ck);
        fifo_empty = 2'b11;
        #1;
        chk("mid.nogrant", 32'(fifo_rd), 32'h0);
        @(negedge ck); #1;
        chk("mid.cap.vld", 32'(out_valid), 32'h1);
        chk("mid.cap.d0", 32'(out_data[6:0]), 32'h09);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
